// File: rtl/dmem_stage.sv
// dmem_stage: multi-cycle data-memory stage between EX/MEM and MEM/WB.
// Word loads/stores against an internal synchronous array. Each access
// spends LATENCY cycles in BUSY, then produces a one-cycle DONE pulse.
// Optional feature macro: DMEM_MISALIGN_CHK_EN. When it is defined, a
// request with addr_i[1:0] != 0 bypasses the array and reports misalign_o.
module dmem_stage #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  mem_ctrl_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        done_o
`ifdef DMEM_MISALIGN_CHK_EN
    ,
    output logic        misalign_o
`endif
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   idx_q;
    logic [31:0]        wdata_q;
    logic               is_read_q;

    logic [31:0]        mem [DEPTH_WORDS];

    logic               req;
    logic               mem_we;
    logic               unused_addr;

    // Any MemRead/MemWrite bit set is a request; bits outside the word index are don't-care.
    assign req         = |mem_ctrl_i;
    assign unused_addr = ^{addr_i[31:IDX_W+2], addr_i[1:0]};

    // Pipeline freeze: the request cycle in IDLE plus every BUSY cycle.
    assign stall_o = ((state == S_IDLE) && req) || (state == S_BUSY);

    // Array write fires on the last BUSY edge; reset on that same edge suppresses it.
    assign mem_we = (state == S_BUSY) && (cnt == '0) && !is_read_q && !rst_i;

    // Access FSM with registered load data and completion pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            cnt        <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            is_read_q  <= 1'b0;
            rdata_o    <= '0;
            done_o     <= 1'b0;
`ifdef DMEM_MISALIGN_CHK_EN
            misalign_o <= 1'b0;
`endif
        end else begin
            done_o     <= 1'b0;
`ifdef DMEM_MISALIGN_CHK_EN
            misalign_o <= 1'b0;
`endif
            unique case (state)
                S_IDLE: begin
                    if (req) begin
                        idx_q     <= addr_i[IDX_W+1:2];
                        wdata_q   <= wdata_i;
                        // 2'b11 counts as a read: bit1 wins over bit0.
                        is_read_q <= mem_ctrl_i[1];
`ifdef DMEM_MISALIGN_CHK_EN
                        if (addr_i[1:0] != 2'b00) begin
                            state      <= S_DONE;
                            done_o     <= 1'b1;
                            misalign_o <= 1'b1;
                            if (mem_ctrl_i[1]) begin
                                rdata_o <= '0;
                            end
                        end else begin
                            state <= S_BUSY;
                            cnt   <= CNT_W'(LATENCY - 1);
                        end
`else
                        state <= S_BUSY;
                        cnt   <= CNT_W'(LATENCY - 1);
`endif
                    end
                end
                S_BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        if (is_read_q) begin
                            rdata_o <= mem[idx_q];
                        end
                        state  <= S_DONE;
                        done_o <= 1'b1;
                    end
                end
                S_DONE: begin
                    // Inputs still carry the finished request; do not re-accept it.
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Storage array; deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[idx_q] <= wdata_q;
        end
    end

endmodule
